alu_wb_mod: RTL and testbench

Result-side partner of `alu_mod`. It accepts each ALU result and its C/V flags through a valid/ready handshake. It keeps the architectural status flags (C, V, Z, N), and it feeds the registered carry back to the ALU for add-with-carry. It buffers register-file writes in a 2-entry FIFO toward the register-file write port. It sits between the execute stage and the register file in the RISC pipeline.

---
 rtl/alu_wb_mod_if.sv | 38 +++
 rtl/alu_wb_mod.sv | 84 ++++++++
 tb/tb_alu_wb_mod.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_wb_mod_if.sv
// Execute-to-writeback bus: ALU result beats in, register-file write requests and status flags out.
// master drives the ALU beat and register-file ready; slave is the writeback block.
interface alu_wb_mod_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_result_i;
    logic              in_c_flag_i;
    logic              in_v_flag_i;
    logic [ADDR_W-1:0] in_rd_i;
    logic              in_we_i;
    logic              in_setflags_i;
    logic              flush_i;
    logic              rf_valid_o;
    logic              rf_ready_i;
    logic [ADDR_W-1:0] rf_waddr_o;
    logic [DATA_W-1:0] rf_wdata_o;
    logic              flag_c_o;
    logic              flag_v_o;
    logic              flag_z_o;
    logic              flag_n_o;

    modport master (
        output in_valid_i, in_result_i, in_c_flag_i, in_v_flag_i, in_rd_i,
               in_we_i, in_setflags_i, flush_i, rf_ready_i,
        input  in_ready_o, rf_valid_o, rf_waddr_o, rf_wdata_o,
               flag_c_o, flag_v_o, flag_z_o, flag_n_o
    );

    modport slave (
        input  in_valid_i, in_result_i, in_c_flag_i, in_v_flag_i, in_rd_i,
               in_we_i, in_setflags_i, flush_i, rf_ready_i,
        output in_ready_o, rf_valid_o, rf_waddr_o, rf_wdata_o,
               flag_c_o, flag_v_o, flag_z_o, flag_n_o
    );
endinterface

// File: rtl/alu_wb_mod.sv
// Writeback stage: keeps C/V/Z/N status flags and queues register-file writes in a 2-entry FIFO.
// Latency: a write is visible on the rf port and flags update one edge after acceptance.
// Backpressure: in_ready is registered (count != 2); rf_ready only pops, flush empties the FIFO.
module alu_wb_mod #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_wb_mod_if.slave bus
);
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] dat;
    } wb_entry_t;

    wb_entry_t  mem [2];
    logic       head;
    logic       tail;
    logic [1:0] count;
    logic       flag_c;
    logic       flag_v;
    logic       flag_z;
    logic       flag_n;

    logic accept;
    logic push;
    logic pop;

    // Flush wins over everything: the same-cycle beat and pop are both ignored.
    assign bus.in_ready_o = (count != 2'd2);
    assign accept = bus.in_valid_i && bus.in_ready_o && !bus.flush_i;
    assign push   = accept && bus.in_we_i && (bus.in_rd_i != '0);
    assign pop    = (count != 2'd0) && bus.rf_ready_i && !bus.flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
        end else if (bus.flush_i) begin
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[tail] <= wb_entry_t'{rd: bus.in_rd_i, dat: bus.in_result_i};
                tail      <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else if (accept && bus.in_setflags_i) begin
            flag_c <= bus.in_c_flag_i;
            flag_v <= bus.in_v_flag_i;
            flag_z <= (bus.in_result_i == '0);
            flag_n <= bus.in_result_i[DATA_W-1];
        end
    end

    assign bus.rf_valid_o = (count != 2'd0);
    assign bus.rf_waddr_o = mem[head].rd;
    assign bus.rf_wdata_o = mem[head].dat;
    assign bus.flag_c_o   = flag_c;
    assign bus.flag_v_o   = flag_v;
    assign bus.flag_z_o   = flag_z;
    assign bus.flag_n_o   = flag_n;
endmodule

// File: tb/tb_alu_wb_mod.sv
// Bench for alu_wb_mod: directed vector table, async reset sequences, then random traffic vs a queue model.
module tb_alu_wb_mod;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_wb_mod_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    alu_wb_mod #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic          vld;
        logic [AW-1:0] rd;
        logic [DW-1:0] res;
        logic          we, sf, c, v, fl, rfr;
    } in_t;

    typedef struct {
        in_t           i;
        logic          e_rfv;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        logic          e_rdy;
        logic [3:0]    e_f;   // {C,V,Z,N}
    } vec_t;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] d;
    } ent_t;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];
    ent_t q[$];
    logic mc = 1'b0, mv = 1'b0, mz = 1'b0, mn = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic in_t mk(logic vld, logic [AW-1:0] rd, logic [DW-1:0] res,
                               logic we, logic sf, logic c, logic v, logic fl, logic rfr);
        in_t x;
        x.vld = vld; x.rd = rd; x.res = res; x.we = we; x.sf = sf;
        x.c = c; x.v = v; x.fl = fl; x.rfr = rfr;
        return x;
    endfunction

    task automatic add(in_t x, logic rfv, logic [AW-1:0] a, logic [DW-1:0] d,
                       logic rdy, logic [3:0] f);
        vec_t t;
        t.i = x; t.e_rfv = rfv; t.e_a = a; t.e_d = d; t.e_rdy = rdy; t.e_f = f;
        tbl.push_back(t);
    endtask

    task automatic drive(in_t x);
        bus.in_valid_i    = x.vld;
        bus.in_rd_i       = x.rd;
        bus.in_result_i   = x.res;
        bus.in_we_i       = x.we;
        bus.in_setflags_i = x.sf;
        bus.in_c_flag_i   = x.c;
        bus.in_v_flag_i   = x.v;
        bus.flush_i       = x.fl;
        bus.rf_ready_i    = x.rfr;
    endtask

    // Reference: the queue holds pending writes; decisions use the state before the edge.
    task automatic model_step(in_t x);
        bit   ready;
        bit   acc;
        ent_t e;
        ready = (q.size() != 2);
        if (x.fl) begin
            q.delete();
        end else begin
            acc = x.vld && ready;
            if (q.size() > 0 && x.rfr) void'(q.pop_front());
            if (acc && x.we && x.rd != 0) begin
                e.rd = x.rd; e.d = x.res;
                q.push_back(e);
            end
            if (acc && x.sf) begin
                mc = x.c; mv = x.v; mz = (x.res == 0); mn = x.res[DW-1];
            end
        end
    endtask

    function automatic logic [3:0] dut_flags();
        return {bus.flag_c_o, bus.flag_v_o, bus.flag_z_o, bus.flag_n_o};
    endfunction

    task automatic check_model(int n);
        chk($sformatf("rnd%0d rf_valid", n), 32'(bus.rf_valid_o), 32'(q.size() != 0));
        chk($sformatf("rnd%0d in_ready", n), 32'(bus.in_ready_o), 32'(q.size() != 2));
        chk($sformatf("rnd%0d flags", n), 32'(dut_flags()), 32'({mc, mv, mz, mn}));
        if (q.size() != 0) begin
            chk($sformatf("rnd%0d waddr", n), 32'(bus.rf_waddr_o), 32'(q[0].rd));
            chk($sformatf("rnd%0d wdata", n), 32'(bus.rf_wdata_o), q[0].d);
        end
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, " rf_valid"}, 32'(bus.rf_valid_o), 32'd0);
        chk({tag, " waddr"},    32'(bus.rf_waddr_o), 32'd0);
        chk({tag, " wdata"},    bus.rf_wdata_o,      32'd0);
        chk({tag, " in_ready"}, 32'(bus.in_ready_o), 32'd1);
        chk({tag, " flags"},    32'(dut_flags()),    32'd0);
    endtask

    initial begin
        in_t idle;
        in_t x;
        idle = mk(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        add(mk(1, 3, 32'h5,         1, 0, 0, 0, 0, 1), 1, 3, 32'h5,  1, 4'b0000);
        add(idle,                                      0, 0, 0,      1, 4'b0000);
        add(mk(1, 0, 32'hFFFF_FFFE, 0, 1, 1, 0, 0, 1), 0, 0, 0,      1, 4'b1001);
        add(mk(1, 0, 32'h0,         0, 1, 1, 1, 0, 1), 0, 0, 0,      1, 4'b1110);
        add(mk(1, 1, 32'hA,         1, 0, 0, 0, 0, 0), 1, 1, 32'hA,  1, 4'b1110);
        add(mk(1, 2, 32'hB,         1, 0, 0, 0, 0, 0), 1, 1, 32'hA,  0, 4'b1110);
        add(mk(1, 4, 32'hC,         1, 1, 0, 0, 0, 0), 1, 1, 32'hA,  0, 4'b1110);
        add(idle,                                      1, 2, 32'hB,  1, 4'b1110);
        add(idle,                                      0, 0, 0,      1, 4'b1110);
        add(mk(1, 0, 32'h8000_0000, 1, 1, 0, 0, 0, 1), 0, 0, 0,      1, 4'b0001);
        add(mk(1, 5, 32'h11,        1, 0, 0, 0, 0, 0), 1, 5, 32'h11, 1, 4'b0001);
        add(mk(1, 6, 32'h22,        1, 0, 0, 0, 0, 0), 1, 5, 32'h11, 0, 4'b0001);
        add(mk(1, 0, 32'h0,         0, 1, 1, 1, 1, 0), 0, 0, 0,      1, 4'b0001);
        add(mk(1, 7, 32'h33,        1, 0, 0, 0, 0, 0), 1, 7, 32'h33, 1, 4'b0001);
        add(mk(1, 8, 32'h0,         1, 1, 1, 1, 1, 1), 0, 0, 0,      1, 4'b0001);
        add(mk(1, 9, 32'h44,        1, 0, 0, 0, 0, 0), 1, 9, 32'h44, 1, 4'b0001);
        add(mk(1, 10, 32'h55,       1, 0, 0, 0, 0, 1), 1, 10, 32'h55, 1, 4'b0001);
        add(idle,                                      0, 0, 0,      1, 4'b0001);

        drive(idle);
        #12;
        check_reset_outputs("reset");
        #10 rst_n = 1'b1;

        foreach (tbl[k]) begin
            drive(tbl[k].i);
            model_step(tbl[k].i);
            @(posedge clk); #1;
            chk($sformatf("row%0d rf_valid", k), 32'(bus.rf_valid_o), 32'(tbl[k].e_rfv));
            chk($sformatf("row%0d in_ready", k), 32'(bus.in_ready_o), 32'(tbl[k].e_rdy));
            chk($sformatf("row%0d flags", k),    32'(dut_flags()),    32'(tbl[k].e_f));
            if (tbl[k].e_rfv) begin
                chk($sformatf("row%0d waddr", k), 32'(bus.rf_waddr_o), 32'(tbl[k].e_a));
                chk($sformatf("row%0d wdata", k), bus.rf_wdata_o,      tbl[k].e_d);
            end
        end

        // One pending write and carry set, then an asynchronous reset mid-cycle.
        x = mk(1, 12, 32'h77, 1, 1, 1, 0, 0, 0);
        drive(x);
        model_step(x);
        @(posedge clk); #1;
        chk("midop pending", 32'(bus.rf_valid_o), 32'd1);
        chk("midop carry",   32'(bus.flag_c_o),   32'd1);
        drive(idle);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midop reset");
        q.delete();
        mc = 1'b0; mv = 1'b0; mz = 1'b0; mn = 1'b0;
        #1 rst_n = 1'b1;
        model_step(idle);
        @(posedge clk); #1;
        chk("midop entry lost", 32'(bus.rf_valid_o), 32'd0);

        for (int n = 0; n < 400; n++) begin
            x.vld = ($urandom_range(3) != 0);
            x.rd  = AW'($urandom_range(7));
            case ($urandom_range(5))
                0:       x.res = 32'h0;
                1:       x.res = 32'h8000_0000;
                default: x.res = $urandom;
            endcase
            x.we  = ($urandom_range(3) != 0);
            x.sf  = $urandom_range(1) == 1;
            x.c   = $urandom_range(1) == 1;
            x.v   = $urandom_range(1) == 1;
            x.fl  = ($urandom_range(15) == 0);
            x.rfr = ($urandom_range(2) != 0);
            drive(x);
            model_step(x);
            @(posedge clk); #1;
            check_model(n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
